// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: byte-wide memory port, EX redirect and the decode handoff.
// master = fetch stage, slave = surrounding pipeline/memory.
interface if_stage_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_rdata;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        output mem_req, mem_addr, if_valid, if_pc, if_inst,
        input  mem_valid, mem_rdata, jump_en, jump_addr, id_ready
    );

    modport slave (
        input  mem_req, mem_addr, if_valid, if_pc, if_inst,
        output mem_valid, mem_rdata, jump_en, jump_addr, id_ready
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: assembles 32-bit words from four little-endian byte reads and holds them for decode.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          ICACHE_ENTRIES = 16
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.master bus
);
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [1:0]  byte_cnt_r, byte_cnt_s;
    logic        pending_r, pending_s;
    logic [31:0] inst_buf_r, inst_buf_s;
    logic        mem_req_r, mem_req_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic        if_valid_r, if_valid_s;
    logic [31:0] if_pc_r, if_pc_s;
    logic [31:0] if_inst_r, if_inst_s;
    logic        fill_s;
    logic        hit_s;
    logic [31:0] hit_word_s;
    logic [1:0]  unused_jump_s;

    assign unused_jump_s = bus.jump_addr[1:0];

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [31:0]               cache_data_r [ICACHE_ENTRIES];
    logic [TAG_W-1:0]          cache_tag_r  [ICACHE_ENTRIES];
    logic [ICACHE_ENTRIES-1:0] cache_vld_r;
    logic [IDX_W-1:0]          idx_s;

    assign idx_s      = pc_r[IDX_W+1:2];
    assign hit_s      = cache_vld_r[idx_s] && (cache_tag_r[idx_s] == pc_r[31:IDX_W+2]);
    assign hit_word_s = cache_data_r[idx_s];

    // Cache payload arrays; contents are meaningless until the matching valid bit is set
    always_ff @(posedge clk) begin
        if (fill_s) begin
            cache_data_r[idx_s] <= if_inst_s;
            cache_tag_r[idx_s]  <= pc_r[31:IDX_W+2];
        end
    end

    // Per-entry valid bits, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_vld_r <= '0;
        end else if (fill_s) begin
            cache_vld_r[idx_s] <= 1'b1;
        end else begin
            cache_vld_r <= cache_vld_r;
        end
    end
`else
    logic [ICACHE_ENTRIES-1:0] unused_cache_s;

    assign unused_cache_s = '0;
    assign hit_s          = 1'b0;
    assign hit_word_s     = 32'h0000_0000;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            byte_cnt_r <= 2'd0;
            pending_r  <= 1'b0;
            inst_buf_r <= 32'h0000_0000;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_inst_r  <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            byte_cnt_r <= byte_cnt_s;
            pending_r  <= pending_s;
            inst_buf_r <= inst_buf_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            if_valid_r <= if_valid_s;
            if_pc_r    <= if_pc_s;
            if_inst_r  <= if_inst_s;
        end
    end

    // Next-state and next-output logic; a redirect overrides every state
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        byte_cnt_s = byte_cnt_r;
        pending_s  = pending_r;
        inst_buf_s = inst_buf_r;
        mem_req_s  = 1'b0;
        mem_addr_s = mem_addr_r;
        if_valid_s = if_valid_r;
        if_pc_s    = if_pc_r;
        if_inst_s  = if_inst_r;
        fill_s     = 1'b0;
        if (bus.jump_en) begin
            pc_s       = {bus.jump_addr[31:2], 2'b00};
            byte_cnt_s = 2'd0;
            if_valid_s = 1'b0;
            // A response landing in the redirect cycle retires the old request immediately
            if (pending_r && !bus.mem_valid) begin
                state_s = ST_DRAIN;
            end else begin
                state_s   = ST_FETCH;
                pending_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (pending_r && bus.mem_valid) begin
                        pending_s = 1'b0;
                        inst_buf_s[{byte_cnt_r, 3'b000} +: 8] = bus.mem_rdata;
                        if (byte_cnt_r == 2'd3) begin
                            if_inst_s  = {bus.mem_rdata, inst_buf_r[23:0]};
                            if_pc_s    = pc_r;
                            if_valid_s = 1'b1;
                            byte_cnt_s = 2'd0;
                            fill_s     = 1'b1;
                            state_s    = ST_HOLD;
                        end else begin
                            byte_cnt_s = byte_cnt_r + 2'd1;
                            mem_req_s  = 1'b1;
                            mem_addr_s = pc_r + {30'd0, byte_cnt_s};
                            pending_s  = 1'b1;
                        end
                    end else if (!pending_r && (byte_cnt_r == 2'd0) && hit_s) begin
                        if_inst_s  = hit_word_s;
                        if_pc_s    = pc_r;
                        if_valid_s = 1'b1;
                        state_s    = ST_HOLD;
                    end else if (!pending_r) begin
                        mem_req_s  = 1'b1;
                        mem_addr_s = pc_r + {30'd0, byte_cnt_r};
                        pending_s  = 1'b1;
                    end else begin
                        pending_s = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.id_ready) begin
                        if_valid_s = 1'b0;
                        pc_s       = pc_r + 32'd4;
                        byte_cnt_s = 2'd0;
                        state_s    = ST_FETCH;
                    end else begin
                        if_valid_s = if_valid_r;
                    end
                end
                ST_DRAIN: begin
                    if (bus.mem_valid) begin
                        pending_s = 1'b0;
                        state_s   = ST_FETCH;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default: begin
                    pending_s = 1'b0;
                    state_s   = ST_FETCH;
                end
            endcase
        end
    end

    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.if_valid = if_valid_r;
    assign bus.if_pc    = if_pc_r;
    assign bus.if_inst  = if_inst_r;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: byte memory with one-cycle latency, hold, redirects, wrap and reset.
// The cache scenario is compiled only when ICACHE_EN is defined.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic        prev_req  = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    bit          mem_auto  = 1'b1;
    logic [31:0] req_q[$];

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000), .ICACHE_ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0:   mem_byte = 8'h13;
            32'h1:   mem_byte = 8'h00;
            32'h2:   mem_byte = 8'h50;
            32'h3:   mem_byte = 8'h00;
            32'h4:   mem_byte = 8'h93;
            32'h5:   mem_byte = 8'h00;
            32'h6:   mem_byte = 8'h10;
            32'h7:   mem_byte = 8'h00;
            default: mem_byte = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // One clock; logs requests and answers the previous cycle's request
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.mem_req) req_q.push_back(bus.mem_addr);
        if (mem_auto) begin
            bus.mem_valid = prev_req;
            bus.mem_rdata = prev_req ? mem_byte(prev_addr) : 8'h00;
            prev_req      = bus.mem_req;
            prev_addr     = bus.mem_addr;
        end
    endtask

    task automatic run_until_valid(input int max, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!bus.if_valid && cycles < max);
    endtask

    task automatic test_reset();
        bus.mem_valid = 1'b0; bus.mem_rdata = 8'h00; bus.jump_en = 1'b0;
        bus.jump_addr = 32'h0; bus.id_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_vec++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        n_vec++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
        n_vec++; if (bus.if_pc !== 32'h0) begin n_err++; $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); end
        n_vec++; if (bus.if_inst !== 32'h0) begin n_err++; $display("FAIL reset_if_inst: got %h want 0", bus.if_inst); end
        rst = 1'b1;
        req_q.delete();
    endtask

    task automatic test_first_fetch();
        int c;
        run_until_valid(40, c);
        n_vec++; if (bus.if_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", bus.if_valid); end
        n_vec++; if (c != 9) begin n_err++; $display("FAIL first_latency: got %0d cycles want 9", c); end
        n_vec++; if (req_q.size() != 4) begin n_err++; $display("FAIL first_req_count: got %0d want 4", req_q.size()); end
        for (int i = 0; i < 4 && i < req_q.size(); i++) begin
            n_vec++; if (req_q[i] !== 32'(i)) begin n_err++; $display("FAIL first_req_addr%0d: got %h want %h", i, req_q[i], i); end
        end
        n_vec++; if (bus.if_pc !== 32'h0) begin n_err++; $display("FAIL first_if_pc: got %h want 0", bus.if_pc); end
        n_vec++; if (bus.if_inst !== 32'h0050_0013) begin n_err++; $display("FAIL first_if_inst: got %h want 00500013", bus.if_inst); end
    endtask

    task automatic test_hold();
        int c;
        req_q.delete();
        bus.id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0050_0013) begin
                n_err++; $display("FAIL hold_stable%0d: got v=%b pc=%h inst=%h want v=1 pc=0 inst=00500013", i, bus.if_valid, bus.if_pc, bus.if_inst);
            end
        end
        n_vec++; if (req_q.size() != 0) begin n_err++; $display("FAIL hold_no_req: got %0d reqs want 0", req_q.size()); end
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        n_vec++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL accept_drop: got %b want 0", bus.if_valid); end
        run_until_valid(40, c);
        n_vec++; if (req_q.size() < 1 || req_q[0] !== 32'h4) begin n_err++; $display("FAIL next_addr: got %h want 4", req_q.size() > 0 ? req_q[0] : 32'hx); end
        n_vec++; if (bus.if_pc !== 32'h4) begin n_err++; $display("FAIL second_if_pc: got %h want 4", bus.if_pc); end
        n_vec++; if (bus.if_inst !== 32'h0010_0093) begin n_err++; $display("FAIL second_if_inst: got %h want 00100093", bus.if_inst); end
    endtask

    task automatic test_jump_pending();
        int  c;
        bit  found = 1'b0;
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.mem_req && bus.mem_addr == 32'hA) found = 1'b1;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL jp_byte2_req: no request at 0000000a seen"); end
        bus.jump_en = 1'b1; bus.jump_addr = 32'h0000_1006;
        tick();
        bus.jump_en = 1'b0;
        req_q.delete();
        n_vec++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL jp_valid: got %b want 0", bus.if_valid); end
        run_until_valid(40, c);
        n_vec++; if (req_q.size() != 4 || req_q[0] !== 32'h1004) begin
            n_err++; $display("FAIL jp_first_addr: got n=%0d addr=%h want n=4 addr=00001004", req_q.size(), req_q.size() > 0 ? req_q[0] : 32'hx);
        end
        n_vec++; if (bus.if_pc !== 32'h1004) begin n_err++; $display("FAIL jp_if_pc: got %h want 00001004", bus.if_pc); end
        n_vec++; if (bus.if_inst !== 32'hA2A3_A0A1) begin n_err++; $display("FAIL jp_if_inst: got %h want a2a3a0a1", bus.if_inst); end
    endtask

    task automatic test_jump_accept();
        int c;
        bus.jump_en = 1'b1; bus.jump_addr = 32'h0000_0100; bus.id_ready = 1'b1;
        tick();
        bus.jump_en = 1'b0; bus.id_ready = 1'b0;
        req_q.delete();
        n_vec++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL ja_valid: got %b want 0", bus.if_valid); end
        run_until_valid(40, c);
        n_vec++; if (req_q.size() < 1 || req_q[0] !== 32'h100) begin n_err++; $display("FAIL ja_addr: got %h want 00000100", req_q.size() > 0 ? req_q[0] : 32'hx); end
        n_vec++; if (bus.if_pc !== 32'h100) begin n_err++; $display("FAIL ja_if_pc: got %h want 00000100", bus.if_pc); end
        n_vec++; if (bus.if_inst !== 32'hA6A7_A4A5) begin n_err++; $display("FAIL ja_if_inst: got %h want a6a7a4a5", bus.if_inst); end
    endtask

    task automatic test_wrap();
        int c;
        bus.jump_en = 1'b1; bus.jump_addr = 32'hFFFF_FFFE;
        tick();
        bus.jump_en = 1'b0;
        req_q.delete();
        run_until_valid(40, c);
        n_vec++; if (req_q.size() != 4 || req_q[0] !== 32'hFFFF_FFFC || req_q[3] !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL wrap_addrs: got n=%0d want 4 requests fffffffc..ffffffff", req_q.size());
        end
        n_vec++; if (bus.if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_if_pc: got %h want fffffffc", bus.if_pc); end
        n_vec++; if (bus.if_inst !== 32'h5A5B_5859) begin n_err++; $display("FAIL wrap_if_inst: got %h want 5a5b5859", bus.if_inst); end
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        req_q.delete();
        for (int i = 0; i < 5 && req_q.size() == 0; i++) tick();
        n_vec++; if (req_q.size() < 1 || req_q[0] !== 32'h0) begin n_err++; $display("FAIL wrap_next_addr: got %h want 0", req_q.size() > 0 ? req_q[0] : 32'hx); end
    endtask

    task automatic test_reset_mid();
        int c;
        bit found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.mem_req && bus.mem_addr == 32'h1) found = 1'b1;
            else tick();
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL rm_byte1_req: no request at 00000001 seen"); end
        mem_auto = 1'b0;
        bus.mem_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_vec++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0) begin
            n_err++; $display("FAIL rm_async_zero: got req=%b addr=%h v=%b pc=%h inst=%h want all 0", bus.mem_req, bus.mem_addr, bus.if_valid, bus.if_pc, bus.if_inst);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_rdata = 8'hEE;
        req_q.delete();
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
        n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
            n_err++; $display("FAIL rm_restart: got req=%b addr=%h want req=1 addr=0", bus.mem_req, bus.mem_addr);
        end
        if (bus.mem_req) req_q.push_back(bus.mem_addr);
        prev_req = bus.mem_req; prev_addr = bus.mem_addr; mem_auto = 1'b1;
        run_until_valid(40, c);
        n_vec++; if (req_q.size() != 4) begin n_err++; $display("FAIL rm_req_count: got %0d want 4", req_q.size()); end
        n_vec++; if (bus.if_pc !== 32'h0) begin n_err++; $display("FAIL rm_if_pc: got %h want 0", bus.if_pc); end
        n_vec++; if (bus.if_inst !== 32'h0050_0013) begin n_err++; $display("FAIL rm_if_inst: got %h want 00500013", bus.if_inst); end
    endtask

`ifdef ICACHE_EN
    task automatic test_icache();
        int c;
        bus.jump_en = 1'b1; bus.jump_addr = 32'h0000_0010;
        tick();
        bus.jump_en = 1'b0;
        run_until_valid(40, c);
        n_vec++; if (bus.if_inst !== 32'hB6B7_B4B5) begin n_err++; $display("FAIL ic_miss_inst: got %h want b6b7b4b5", bus.if_inst); end
        bus.jump_en = 1'b1; bus.jump_addr = 32'h0000_0010;
        tick();
        bus.jump_en = 1'b0;
        req_q.delete();
        tick();
        n_vec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h10 || bus.if_inst !== 32'hB6B7_B4B5) begin
            n_err++; $display("FAIL ic_hit: got v=%b pc=%h inst=%h want v=1 pc=10 inst=b6b7b4b5", bus.if_valid, bus.if_pc, bus.if_inst);
        end
        n_vec++; if (req_q.size() != 0) begin n_err++; $display("FAIL ic_no_req: got %0d reqs want 0", req_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_fetch();
        test_hold();
        test_jump_pending();
        test_jump_accept();
        test_wrap();
        test_reset_mid();
`ifdef ICACHE_EN
        test_icache();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
